// File: rtl/pl_stage_reg.sv
// pl_stage_reg: reusable pipeline stage register between two pipeline stages.
//   Carries a control vector, NDATA data words and NREG register indices with
//   valid/ready handshaking. The stage also provides an optional 2-entry skid
//   buffer, a synchronous flush that inserts a bubble, and a saturating stall
//   counter.
// Ports:
//   clk, clr         clock; synchronous active-high reset
//   flush            squash every held entry; a payload offered this cycle is dropped
//   in_valid/in_ready, in_ctrl/in_data/in_regs      upstream side
//   out_valid/out_ready, out_ctrl/out_data/out_regs downstream side (registered)
//   stall_cnt        cycles with out_valid && !out_ready, saturating
// SKID=1: in_ready comes from state flops (gated only by flush/clr).
// SKID=0: in_ready = !flush && !clr && (!out_valid || out_ready).

// One payload field: the main register that drives the output, plus a skid
// register. With SKID=0 the skid load is never asserted, so synthesis removes it.
module pl_stage_slice #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         zero,     // clr or flush: empty and zero both entries
  input  logic         ld_main,  // main <= d
  input  logic         ld_skid,  // skid <= d
  input  logic         mv_skid,  // main <= skid, skid emptied
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [W-1:0] skid;

  always_ff @(posedge clk) begin
    if (zero) begin
      q    <= '0;
      skid <= '0;
    end else begin
      if (ld_main)      q <= d;
      else if (mv_skid) q <= skid;
      if (ld_skid)      skid <= d;
      else if (mv_skid) skid <= '0;
    end
  end
endmodule

module pl_stage_reg #(
  parameter int CTRL_W = 8,
  parameter int DATA_W = 32,
  parameter int NDATA  = 4,
  parameter int REG_W  = 5,
  parameter int NREG   = 3,
  parameter int SKID   = 1,
  parameter int CNT_W  = 16
) (
  input  logic                    clk,
  input  logic                    clr,
  input  logic                    flush,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [CTRL_W-1:0]       in_ctrl,
  input  logic [NDATA*DATA_W-1:0] in_data,
  input  logic [NREG*REG_W-1:0]   in_regs,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [CTRL_W-1:0]       out_ctrl,
  output logic [NDATA*DATA_W-1:0] out_data,
  output logic [NREG*REG_W-1:0]   out_regs,
  output logic [CNT_W-1:0]        stall_cnt
);
  typedef enum logic [1:0] {S_EMPTY, S_ONE, S_TWO} state_t;

  state_t state;
  logic   in_fire, out_fire, zero, ld_main, ld_skid, mv_skid;

  assign zero      = clr | flush;
  assign out_valid = (state != S_EMPTY);
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;

  generate
    if (SKID != 0) begin : g_skid_rdy
      assign in_ready = (state != S_TWO) && !flush && !clr;
    end else begin : g_comb_rdy
      assign in_ready = !flush && !clr && (!out_valid || out_ready);
    end
  endgenerate

  // Input goes to main when main is empty or is being drained this cycle;
  // otherwise it parks in skid. With SKID=0, in_fire while holding implies
  // out_fire, so ld_skid never rises and S_TWO is unreachable.
  assign ld_main = in_fire && ((state == S_EMPTY) || out_fire);
  assign ld_skid = in_fire && (state == S_ONE) && !out_fire;
  assign mv_skid = out_fire && (state == S_TWO);

  always_ff @(posedge clk) begin
    if (zero) begin
      state <= S_EMPTY;
    end else begin
      case (state)
        S_EMPTY: if (in_fire) state <= S_ONE;
        S_ONE: begin
          if (in_fire && !out_fire)      state <= S_TWO;
          else if (!in_fire && out_fire) state <= S_EMPTY;
        end
        S_TWO:   if (out_fire) state <= S_ONE;
        default: state <= S_EMPTY;
      endcase
    end
  end

  // Flush holds the counter; only clr clears it.
  always_ff @(posedge clk) begin
    if (clr)
      stall_cnt <= '0;
    else if (!flush && out_valid && !out_ready && (stall_cnt != {CNT_W{1'b1}}))
      stall_cnt <= stall_cnt + CNT_W'(1);
  end

  pl_stage_slice #(.W(CTRL_W)) u_ctrl (
    .clk(clk), .zero(zero), .ld_main(ld_main), .ld_skid(ld_skid), .mv_skid(mv_skid),
    .d(in_ctrl), .q(out_ctrl)
  );

  generate
    for (genvar k = 0; k < NDATA; k++) begin : g_data
      pl_stage_slice #(.W(DATA_W)) u_word (
        .clk(clk), .zero(zero), .ld_main(ld_main), .ld_skid(ld_skid), .mv_skid(mv_skid),
        .d(in_data[k*DATA_W +: DATA_W]), .q(out_data[k*DATA_W +: DATA_W])
      );
    end
    for (genvar k = 0; k < NREG; k++) begin : g_regs
      pl_stage_slice #(.W(REG_W)) u_idx (
        .clk(clk), .zero(zero), .ld_main(ld_main), .ld_skid(ld_skid), .mv_skid(mv_skid),
        .d(in_regs[k*REG_W +: REG_W]), .q(out_regs[k*REG_W +: REG_W])
      );
    end
  endgenerate
endmodule

// File: tb/tb_pl_stage_reg.sv
// Bench for pl_stage_reg. Two instances share one input stream:
//   dut0 uses SKID=1 and CNT_W=16; dut1 uses SKID=0 and CNT_W=4.
// Each instance has its own queue model of the stage's capacity and FIFO order.
module tb_pl_stage_reg;
  localparam int CTRL_W = 8, DATA_W = 32, NDATA = 4, REG_W = 5, NREG = 3;
  localparam int PW = CTRL_W + NDATA*DATA_W + NREG*REG_W;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                    clr, flush, in_valid, out_ready;
  logic [CTRL_W-1:0]       in_ctrl;
  logic [NDATA*DATA_W-1:0] in_data;
  logic [NREG*REG_W-1:0]   in_regs;

  logic                    rdy0, vld0, rdy1, vld1;
  logic [CTRL_W-1:0]       ctrl0, ctrl1;
  logic [NDATA*DATA_W-1:0] data0, data1;
  logic [NREG*REG_W-1:0]   regs0, regs1;
  logic [15:0]             cnt0;
  logic [3:0]              cnt1;
  logic [PW-1:0]           pin, pout0, pout1;

  assign pin   = {in_ctrl, in_data, in_regs};
  assign pout0 = {ctrl0, data0, regs0};
  assign pout1 = {ctrl1, data1, regs1};

  pl_stage_reg #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .NDATA(NDATA), .REG_W(REG_W),
                 .NREG(NREG), .SKID(1), .CNT_W(16)) dut0 (
    .clk(clk), .clr(clr), .flush(flush), .in_valid(in_valid), .in_ready(rdy0),
    .in_ctrl(in_ctrl), .in_data(in_data), .in_regs(in_regs),
    .out_valid(vld0), .out_ready(out_ready), .out_ctrl(ctrl0), .out_data(data0),
    .out_regs(regs0), .stall_cnt(cnt0)
  );

  pl_stage_reg #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .NDATA(NDATA), .REG_W(REG_W),
                 .NREG(NREG), .SKID(0), .CNT_W(4)) dut1 (
    .clk(clk), .clr(clr), .flush(flush), .in_valid(in_valid), .in_ready(rdy1),
    .in_ctrl(in_ctrl), .in_data(in_data), .in_regs(in_regs),
    .out_valid(vld1), .out_ready(out_ready), .out_ctrl(ctrl1), .out_data(data1),
    .out_regs(regs1), .stall_cnt(cnt1)
  );

  // Model state.
  // sbN   holds payloads accepted but not yet delivered; the head is on the output.
  // lastN holds what the output shows when nothing is held.
  // mN    is the stall count.
  // erN   is the expected in_ready for the upcoming edge.
  logic [PW-1:0] sb0[$], sb1[$];
  logic [PW-1:0] last0, last1;
  int            m0, m1;
  bit            er0 = 1'b0, er1 = 1'b0, started = 1'b0;
  int            nvec = 0, nerr = 0;

  task automatic chk(input string nm, input int d, input logic [PW-1:0] act,
                     input logic [PW-1:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s dut%0d got %h expected %h", nm, d, act, exp);
    end
  endtask

  // Model update at the active edge, using the inputs that were stable before it.
  initial forever begin
    @(posedge clk);
    started = 1'b1;
    if (clr) begin
      sb0.delete(); sb1.delete();
      last0 = '0; last1 = '0; m0 = 0; m1 = 0;
    end else if (flush) begin
      sb0.delete(); sb1.delete();
      last0 = '0; last1 = '0;
    end else begin
      if (sb0.size() > 0 && !out_ready && m0 != 65535) m0++;
      if (sb1.size() > 0 && !out_ready && m1 != 15)    m1++;
      if (in_valid && er0) sb0.push_back(pin);
      if (in_valid && er1) sb1.push_back(pin);
    end
  end

  // Monitor at the opposite edge. Inputs for the next edge are already applied here.
  initial forever begin
    @(negedge clk);
    if (started) begin
      er0 = !clr && !flush && (sb0.size() < 2);
      er1 = !clr && !flush && (sb1.size() == 0 || out_ready);
      chk("in_ready",  0, PW'(rdy0), PW'(er0));
      chk("out_valid", 0, PW'(vld0), PW'(sb0.size() > 0));
      chk("payload",   0, pout0, (sb0.size() > 0) ? sb0[0] : last0);
      chk("stall_cnt", 0, PW'(cnt0), PW'(m0));
      chk("in_ready",  1, PW'(rdy1), PW'(er1));
      chk("out_valid", 1, PW'(vld1), PW'(sb1.size() > 0));
      chk("payload",   1, pout1, (sb1.size() > 0) ? sb1[0] : last1);
      chk("stall_cnt", 1, PW'(cnt1), PW'(m1));
      // Pop the head when it transfers at the next edge.
      if (!clr && !flush && out_ready && sb0.size() > 0) last0 = sb0.pop_front();
      if (!clr && !flush && out_ready && sb1.size() > 0) last1 = sb1.pop_front();
    end
  end

  // Drive one cycle of inputs with a random payload.
  // When setw is set, data word 0 is forced to w0.
  task automatic step(input bit c, input bit f, input bit iv, input bit orr,
                      input bit setw = 1'b0, input logic [31:0] w0 = '0);
    clr = c; flush = f; in_valid = iv; out_ready = orr;
    in_ctrl = CTRL_W'($urandom);
    for (int k = 0; k < NDATA; k++) in_data[k*DATA_W +: DATA_W] = DATA_W'($urandom);
    in_regs = (NREG*REG_W)'($urandom);
    if (setw) in_data[DATA_W-1:0] = w0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset for 2 cycles, then stream 1..8 with the downstream always ready.
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    for (int i = 1; i <= 8; i++) step(0, 0, 1, 1, 1'b1, 32'(i));
    repeat (2) step(0, 0, 0, 1);

    // Backpressure: A then B with the downstream stalled, then release.
    step(0, 0, 1, 0, 1'b1, 32'hAAAA_0001);
    step(0, 0, 1, 0, 1'b1, 32'hBBBB_0002);
    repeat (3) step(0, 0, 0, 0);
    repeat (3) step(0, 0, 0, 1);

    // Flush while two entries are held; C arrives in the flush cycle.
    step(0, 0, 1, 0);
    step(0, 0, 1, 0);
    step(0, 1, 1, 0, 1'b1, 32'hCCCC_0003);
    repeat (2) step(0, 0, 0, 1);

    // clr beats flush once stall_cnt has reached 5.
    step(1, 0, 0, 0);
    step(0, 0, 1, 0);
    repeat (5) step(0, 0, 0, 0);
    step(1, 1, 1, 0);
    step(0, 0, 0, 1);

    // SKID=0: ready follows out_ready while holding. Then back-to-back 0x10, 0x11.
    step(0, 0, 1, 0);
    step(0, 0, 0, 1);
    step(0, 0, 0, 0);
    step(0, 0, 0, 1);
    step(0, 0, 1, 1, 1'b1, 32'h10);
    step(0, 0, 1, 1, 1'b1, 32'h11);
    repeat (2) step(0, 0, 0, 1);

    // Saturation: 20 stalled cycles. The 4-bit counter in dut1 stops at 15.
    step(1, 0, 0, 0);
    step(0, 0, 1, 0);
    repeat (20) step(0, 0, 0, 0);
    repeat (2) step(0, 0, 0, 1);

    // Random traffic with occasional flush and clr.
    repeat (3000) begin
      automatic int r = $urandom_range(0, 99);
      step(r == 0, (r >= 1 && r <= 3), ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 2) != 0));
    end
    repeat (4) step(0, 0, 0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
